// File: rtl/rsa_pkg.sv
// Shared RSA datapath types and defaults.
// Used by the modular exponentiator and its multiplier.
package rsa_pkg;

  localparam int KEY_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    FIN
  } state_t;

  typedef enum logic {
    PH_LAUNCH,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/mod_mul.sv
// Interleaved MSB-first shift-add modular multiplier.
// One multiplier bit per cycle; done pulses after KEY_WIDTH cycles.
module mod_mul
  import rsa_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] a,
  input  logic [KEY_WIDTH-1:0] b,
  input  logic [KEY_WIDTH-1:0] n,
  output logic                 done,
  output logic [KEY_WIDTH-1:0] r
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);

  logic                 run;
  logic [CW-1:0]        cnt;
  logic [KEY_WIDTH:0]   r_q;
  logic [KEY_WIDTH:0]   a_q;
  logic [KEY_WIDTH:0]   n_q;
  logic [KEY_WIDTH-1:0] b_q;
  logic [KEY_WIDTH:0]   dbl;
  logic [KEY_WIDTH:0]   dbl_r;
  logic [KEY_WIDTH:0]   add;
  logic [KEY_WIDTH:0]   add_r;

  assign r = r_q[KEY_WIDTH-1:0];

  // One iteration: double, reduce, conditionally add a, reduce.
  // r_q < n always, so one extra bit is enough for 2r and r+a.
  always_comb begin
    dbl   = r_q << 1;
    dbl_r = (dbl >= n_q) ? dbl - n_q : dbl;
    add   = b_q[KEY_WIDTH-1] ? dbl_r + a_q : dbl_r;
    add_r = (add >= n_q) ? add - n_q : add;
  end

  // Operand load on start, then KEY_WIDTH iterations.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      r_q <= '0;
      a_q <= '0;
      n_q <= '0;
      b_q <= '0;
    end else if (start && !run) begin
      run <= 1'b1;
      cnt <= '0;
      r_q <= '0;
      a_q <= {1'b0, a};
      n_q <= {1'b0, n};
      b_q <= b;
    end else if (run) begin
      r_q <= add_r;
      b_q <= b_q << 1;
      if (cnt == LAST) begin
        run  <= 1'b0;
        done <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_exp.sv
// Constant-time right-to-left modular exponentiation.
// Square and product run concurrently on two multipliers.
module mod_exp
  import rsa_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] msg,
  input  logic [KEY_WIDTH-1:0] exp,
  input  logic [KEY_WIDTH-1:0] n,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [KEY_WIDTH-1:0] result
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);
  localparam logic [KEY_WIDTH-1:0] ONE = KEY_WIDTH'(1);
  localparam logic [KEY_WIDTH-1:0] TWO = KEY_WIDTH'(2);

  state_t               state;
  phase_t               phase;
  logic [KEY_WIDTH-1:0] base;
  logic [KEY_WIDTH-1:0] acc;
  logic [KEY_WIDTH-1:0] e_sh;
  logic [KEY_WIDTH-1:0] n_q;
  logic [CW-1:0]        bitcnt;
  logic                 err_q;
  logic                 mul_go;
  logic                 sq_done;
  logic                 pr_done;
  logic [KEY_WIDTH-1:0] sq;
  logic [KEY_WIDTH-1:0] pr;

  assign mul_go = (state == RUN) && (phase == PH_LAUNCH);

  mod_mul #(.KEY_WIDTH(KEY_WIDTH)) u_sq (
    .clk  (clk),
    .rst  (rst),
    .start(mul_go),
    .a    (base),
    .b    (base),
    .n    (n_q),
    .done (sq_done),
    .r    (sq)
  );

  mod_mul #(.KEY_WIDTH(KEY_WIDTH)) u_pr (
    .clk  (clk),
    .rst  (rst),
    .start(mul_go),
    .a    (acc),
    .b    (base),
    .n    (n_q),
    .done (pr_done),
    .r    (pr)
  );

  // Control FSM: latch, validate, one bit per K+2 cycles, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= PH_LAUNCH;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      bitcnt <= '0;
      base   <= '0;
      acc    <= '0;
      e_sh   <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base  <= msg;
            e_sh  <= exp;
            n_q   <= n;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          bitcnt <= '0;
          phase  <= PH_LAUNCH;
          if (n_q < TWO || base >= n_q) begin
            err_q <= 1'b1;
            acc   <= '0;
            state <= FIN;
          end else begin
            err_q <= 1'b0;
            acc   <= ONE;
            state <= RUN;
          end
        end
        RUN: begin
          unique case (phase)
            PH_LAUNCH: phase <= PH_WAIT;
            PH_WAIT: begin
              if (sq_done && pr_done) begin
                base  <= sq;
                if (e_sh[0]) acc <= pr;
                e_sh  <= e_sh >> 1;
                phase <= PH_LAUNCH;
                if (bitcnt == LAST) begin
                  bitcnt <= '0;
                  state  <= FIN;
                end else begin
                  bitcnt <= bitcnt + 1'b1;
                end
              end
            end
            default: phase <= PH_LAUNCH;
          endcase
        end
        FIN: begin
          result <= acc;
          err    <= err_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp at KEY_WIDTH 8 and 64.
// Expected values are hand-computed RSA results.
module tb_mod_exp;

  logic clk = 1'b0;
  logic rst;

  logic       start8;
  logic [7:0] msg8, exp8, n8;
  logic       busy8, done8, err8;
  logic [7:0] result8;

  logic        start64;
  logic [63:0] msg64, exp64, n64;
  logic        busy64, done64, err64;
  logic [63:0] result64;

  int tests = 0;
  int fails = 0;

  mod_exp #(.KEY_WIDTH(8)) u8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .msg   (msg8),
    .exp   (exp8),
    .n     (n8),
    .busy  (busy8),
    .done  (done8),
    .err   (err8),
    .result(result8)
  );

  mod_exp #(.KEY_WIDTH(64)) u64 (
    .clk   (clk),
    .rst   (rst),
    .start (start64),
    .msg   (msg64),
    .exp   (exp64),
    .n     (n64),
    .busy  (busy64),
    .done  (done64),
    .err   (err64),
    .result(result64)
  );

  initial forever #5 clk = ~clk;

  // Launch one 8-bit op; lat = edges from accept to done, -1 on timeout.
  // If now is set, start is driven in the current cycle.
  task automatic run8(input logic [7:0] m, input logic [7:0] e,
                      input logic [7:0] nn, input bit now,
                      output logic [7:0] res, output logic er,
                      output int lat);
    if (!now) @(negedge clk);
    msg8 = m; exp8 = e; n8 = nn; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    res = result8;
    er  = err8;
    if (!done8) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; start64 = 1'b0;
    msg8 = '0; exp8 = '0; n8 = '0;
    msg64 = '0; exp64 = '0; n64 = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy8, done8, err8} !== 3'b000 || result8 !== 8'd0) begin
      fails++;
      $display("FAIL reset8: busy/done/err=%b%b%b result=%0d want 000 0",
               busy8, done8, err8, result8);
    end
    tests++;
    if ({busy64, done64, err64} !== 3'b000 || result64 !== 64'd0) begin
      fails++;
      $display("FAIL reset64: busy/done/err=%b%b%b result=%0d want 000 0",
               busy64, done64, err64, result64);
    end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    logic [7:0] res; logic er; int lat;
    run8(8'd42, 8'd7, 8'd143, 1'b0, res, er, lat);
    tests++;
    if (res !== 8'd81 || er !== 1'b0) begin
      fails++;
      $display("FAIL encrypt: result=%0d err=%b want 81 0", res, er);
    end
    tests++;
    if (lat !== 82) begin
      fails++;
      $display("FAIL encrypt_latency: got %0d want 82", lat);
    end
    @(negedge clk);
    tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || result8 !== 8'd81) begin
      fails++;
      $display("FAIL done_pulse: done=%b busy=%b result=%0d want 0 0 81",
               done8, busy8, result8);
    end
  endtask

  task automatic test_decrypt();
    logic [7:0] res; logic er; int lat;
    run8(8'd81, 8'd103, 8'd143, 1'b0, res, er, lat);
    tests++;
    if (res !== 8'd42 || er !== 1'b0 || lat !== 82) begin
      fails++;
      $display("FAIL decrypt: result=%0d err=%b lat=%0d want 42 0 82",
               res, er, lat);
    end
  endtask

  task automatic test_corners();
    logic [7:0] res; logic er; int lat;
    logic [7:0] m [6];
    logic [7:0] e [6];
    logic [7:0] nn [6];
    logic [7:0] want [6];
    m = '{8'd42, 8'd0, 8'd1, 8'd142, 8'd254, 8'd2};
    e = '{8'd0, 8'd5, 8'd200, 8'd255, 8'd3, 8'd10};
    nn = '{8'd143, 8'd143, 8'd143, 8'd143, 8'd255, 8'd255};
    want = '{8'd1, 8'd0, 8'd1, 8'd142, 8'd254, 8'd4};
    for (int i = 0; i < 6; i++) begin
      run8(m[i], e[i], nn[i], 1'b0, res, er, lat);
      tests++;
      if (res !== want[i] || er !== 1'b0 || lat !== 82) begin
        fails++;
        $display("FAIL corner%0d: result=%0d err=%b lat=%0d want %0d 0 82",
                 i, res, er, lat, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] res; logic er; int lat;
    logic [7:0] m [3];
    logic [7:0] nn [3];
    m = '{8'd143, 8'd0, 8'd0};
    nn = '{8'd143, 8'd1, 8'd0};
    for (int i = 0; i < 3; i++) begin
      run8(m[i], 8'd7, nn[i], 1'b0, res, er, lat);
      tests++;
      if (er !== 1'b1 || res !== 8'd0 || lat !== 2) begin
        fails++;
        $display("FAIL error%0d: err=%b result=%0d lat=%0d want 1 0 2",
                 i, er, res, lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    msg8 = 8'd42; exp8 = 8'd7; n8 = 8'd143; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    msg8 = 8'd5; exp8 = 8'd3; n8 = 8'd200;
    repeat (10) @(negedge clk);
    tests++;
    if (busy8 !== 1'b1) begin
      fails++;
      $display("FAIL busy_high: busy=%b want 1", busy8);
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 11;
    while (!done8 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (result8 !== 8'd81 || err8 !== 1'b0 || lat !== 82) begin
      fails++;
      $display("FAIL busy_ignore: result=%0d err=%b lat=%0d want 81 0 82",
               result8, err8, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res; logic er; int lat;
    run8(8'd42, 8'd7, 8'd143, 1'b0, res, er, lat);
    run8(8'd81, 8'd103, 8'd143, 1'b1, res, er, lat);
    tests++;
    if (res !== 8'd42 || er !== 1'b0 || lat !== 82) begin
      fails++;
      $display("FAIL back_to_back: result=%0d err=%b lat=%0d want 42 0 82",
               res, er, lat);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] res; logic er; int lat;
    @(negedge clk);
    msg8 = 8'd42; exp8 = 8'd7; n8 = 8'd143; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start8 = 1'b0;
    tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done=%b result=%0d want 0 0 0",
               busy8, done8, result8);
    end
    @(negedge clk);
    tests++;
    if (busy8 !== 1'b0) begin
      fails++;
      $display("FAIL start_in_reset: busy=%b want 0", busy8);
    end
    run8(8'd81, 8'd103, 8'd143, 1'b0, res, er, lat);
    tests++;
    if (res !== 8'd42 || er !== 1'b0 || lat !== 82) begin
      fails++;
      $display("FAIL after_reset: result=%0d err=%b lat=%0d want 42 0 82",
               res, er, lat);
    end
  endtask

  task automatic test_rsa64();
    logic [63:0] m [2];
    logic [63:0] e [2];
    logic [63:0] want [2];
    int lat;
    m = '{64'd65, 64'd2790};
    e = '{64'd65537, 64'd2753};
    want = '{64'd2790, 64'd65};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      msg64 = m[i]; exp64 = e[i]; n64 = 64'd3233; start64 = 1'b1;
      @(negedge clk);
      start64 = 1'b0;
      lat = 0;
      while (!done64 && lat < 10000) begin
        @(negedge clk);
        lat++;
      end
      tests++;
      if (result64 !== want[i] || err64 !== 1'b0 || lat !== 4226) begin
        fails++;
        $display("FAIL rsa64_%0d: result=%0d err=%b lat=%0d want %0d 0 4226",
                 i, result64, err64, lat, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_corners();
    test_errors();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_rsa64();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
